// File: rtl/lighthouse_emitter_if.sv
// Request/response bundle for lighthouse_emitter: start request, LFSR setup,
// timestamp in, and the emitted envelope/data pin pair plus status out.
interface lighthouse_emitter_if;
  logic        start;
  logic [16:0] polynomial;
  logic [16:0] seed;
  logic [7:0]  bit_count;
  logic [23:0] sys_ts;
  logic        envelop_wire;
  logic        data_wire;
  logic        busy;
  logic        done;
  logic [23:0] tx_ts;
  logic [16:0] final_state;

  modport master (
    output start, polynomial, seed, bit_count, sys_ts,
    input  envelop_wire, data_wire, busy, done, tx_ts, final_state
  );
  modport slave (
    input  start, polynomial, seed, bit_count, sys_ts,
    output envelop_wire, data_wire, busy, done, tx_ts, final_state
  );
endinterface

// File: rtl/lighthouse_emitter.sv
// Lighthouse beam-hit emitter: envelope low plus BMC-encoded 17-bit LFSR stream.
// Optional LIGHTHOUSE_EMITTER_TS_CAPTURE_EN enables the tx_ts capture register.
module lighthouse_emitter #(
  parameter int HALF_BIT_CYCLES = 8,
  parameter int GAP_CYCLES      = 16
) (
  input  logic clk_96MHz,
  input  logic reset_n,
  lighthouse_emitter_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [7:0] HB_RELOAD  = 8'(HALF_BIT_CYCLES - 1);
  localparam logic [7:0] GAP_RELOAD = (GAP_CYCLES > 1) ? 8'(GAP_CYCLES - 2) : 8'd0;

  logic [1:0]  state;
  logic [7:0]  hb_cnt;
  logic [7:0]  rem_cnt;
  logic [7:0]  gap_cnt;
  logic        second_half;
  logic [16:0] lfsr;
  logic [16:0] poly;
  logic        env_q;
  logic        data_q;
  logic        done_q;
  logic [16:0] final_q;
  logic        accept;
  logic [16:0] lfsr_next;

  // The done cycle is already IDLE but must not accept; next start is one cycle later.
  assign accept    = (state == S_IDLE) && !done_q && bus.start && (bus.bit_count != 8'd0);
  assign lfsr_next = {lfsr[15:0], 1'b0} ^ (lfsr[16] ? poly : 17'd0);

  always_ff @(posedge clk_96MHz or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      hb_cnt      <= '0;
      rem_cnt     <= '0;
      gap_cnt     <= '0;
      second_half <= 1'b0;
      lfsr        <= '0;
      poly        <= '0;
      env_q       <= 1'b1;
      data_q      <= 1'b0;
      done_q      <= 1'b0;
      final_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state       <= S_SEND;
            lfsr        <= bus.seed;
            poly        <= bus.polynomial;
            rem_cnt     <= bus.bit_count;
            hb_cnt      <= HB_RELOAD;
            second_half <= 1'b0;
            env_q       <= 1'b0;
            data_q      <= 1'b1;
          end
        end
        S_SEND: begin
          if (hb_cnt != 8'd0) begin
            hb_cnt <= hb_cnt - 8'd1;
          end else begin
            hb_cnt <= HB_RELOAD;
            if (!second_half) begin
              second_half <= 1'b1;
              if (lfsr[16]) data_q <= ~data_q;
            end else begin
              second_half <= 1'b0;
              lfsr        <= lfsr_next;
              rem_cnt     <= rem_cnt - 8'd1;
              if (rem_cnt == 8'd1) begin
                // Pulse ends on the bit boundary regardless of BMC phase.
                env_q   <= 1'b1;
                data_q  <= 1'b0;
                final_q <= lfsr_next;
                if (GAP_CYCLES == 1) begin
                  state  <= S_IDLE;
                  done_q <= 1'b1;
                end else begin
                  state   <= S_GAP;
                  gap_cnt <= GAP_RELOAD;
                end
              end else begin
                data_q <= ~data_q;
              end
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == 8'd0) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.envelop_wire = env_q;
  assign bus.data_wire    = data_q;
  assign bus.busy         = (state != S_IDLE);
  assign bus.done         = done_q;
  assign bus.final_state  = final_q;

`ifdef LIGHTHOUSE_EMITTER_TS_CAPTURE_EN
  logic [23:0] ts_q;
  always_ff @(posedge clk_96MHz or negedge reset_n) begin
    if (!reset_n)    ts_q <= '0;
    else if (accept) ts_q <= bus.sys_ts;
  end
  assign bus.tx_ts = ts_q;
`else
  logic unused_ts;
  assign unused_ts = ^bus.sys_ts;
  assign bus.tx_ts = '0;
`endif
endmodule

// File: tb/tb_lighthouse_emitter.sv
// Directed bench for lighthouse_emitter: per-cycle waveform checks plus a
// scoreboard of final_state/tx_ts expectations popped at each done pulse.
module tb_lighthouse_emitter;
  localparam int H = 8;
  localparam int G = 16;

  logic clk_96MHz = 1'b0;
  logic reset_n   = 1'b0;
  always #5 clk_96MHz = ~clk_96MHz;

  lighthouse_emitter_if bus ();

  lighthouse_emitter #(.HALF_BIT_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clk_96MHz (clk_96MHz),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  typedef struct packed {
    logic [16:0] final_state;
    logic [23:0] tx_ts;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [16:0] last_final = '0;
  logic [23:0] last_ts    = '0;

  task automatic tick();
    @(posedge clk_96MHz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] lfsr_step(input logic [16:0] s, input logic [16:0] p);
    logic [16:0] r;
    r = {s[15:0], 1'b0};
    if (s[16]) r = r ^ p;
    return r;
  endfunction

  function automatic logic [23:0] ts_expect(input logic [23:0] ts);
`ifdef LIGHTHOUSE_EMITTER_TS_CAPTURE_EN
    return ts;
`else
    return 24'h0;
`endif
  endfunction

  // Starts a pulse from an idle cycle, checks every cycle through done, then
  // one idle cycle after. glitch_at: cycle offset of a stray start (0 = none).
  // b2b holds start high in the done cycle, which must not be accepted.
  task automatic run_pulse(input logic [16:0] sd, input logic [16:0] pl,
                           input logic [7:0] n, input logic [23:0] ts,
                           input int glitch_at, input bit b2b);
    logic [16:0] st;
    logic [254:0] bitv;
    logic ed, ee;
    int total, p, b;
    exp_t e;
    st = sd;
    bitv = '0;
    for (int i = 0; i < int'(n); i++) begin
      bitv[i] = st[16];
      st = lfsr_step(st, pl);
    end
    e.final_state = st;
    e.tx_ts       = ts_expect(ts);
    exp_q.push_back(e);

    bus.seed = sd; bus.polynomial = pl; bus.bit_count = n; bus.sys_ts = ts;
    bus.start = 1'b1;
    tick();
    total = 2 * H * int'(n) + G;
    ed = 1'b0;
    for (int c = 1; c <= total; c++) begin
      if (c > 1) tick();
      bus.sys_ts = ts + 24'(c);
      bus.seed = ~sd; bus.polynomial = ~pl; bus.bit_count = n + 8'd1;
      bus.start = (c == glitch_at) || (b2b && c == total);
      if (c <= 2 * H * int'(n)) begin
        p = (c - 1) % (2 * H);
        b = (c - 1) / (2 * H);
        if (p == 0) ed = ~ed;
        else if (p == H && bitv[b]) ed = ~ed;
        ee = 1'b0;
      end else begin
        ed = 1'b0;
        ee = 1'b1;
      end
      chk("wave", {28'd0, bus.envelop_wire, bus.data_wire, bus.busy, bus.done},
          {28'd0, ee, ed, (c < total), (c == total)});
      if (c == 1) chk("tx_ts_t1", {8'd0, bus.tx_ts}, {8'd0, ts_expect(ts)});
      if (c == 2 * H * int'(n) + 1) chk("final_at_end", {15'd0, bus.final_state}, {15'd0, st});
    end
    chk("sb_nonempty", exp_q.size(), (exp_q.size() > 0) ? exp_q.size() : 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_final", {15'd0, bus.final_state}, {15'd0, e.final_state});
      chk("sb_tx_ts", {8'd0, bus.tx_ts}, {8'd0, e.tx_ts});
      last_final = e.final_state;
      last_ts    = e.tx_ts;
    end
    if (!b2b) bus.start = 1'b0;
    tick();
    chk("post_done_idle", {28'd0, bus.envelop_wire, bus.data_wire, bus.busy, bus.done}, 32'h8);
    chk("final_held", {15'd0, bus.final_state}, {15'd0, last_final});
  endtask

  initial begin
    bus.start = 1'b0; bus.seed = '0; bus.polynomial = '0; bus.bit_count = '0; bus.sys_ts = '0;
    reset_n = 1'b0;
    tick(); tick();
    chk("rst_wave", {28'd0, bus.envelop_wire, bus.data_wire, bus.busy, bus.done}, 32'h8);
    chk("rst_tx_ts", {8'd0, bus.tx_ts}, 32'h0);
    chk("rst_final", {15'd0, bus.final_state}, 32'h0);
    reset_n = 1'b1;
    tick(); tick();

    // Single 1 bit, timestamp capture.
    run_pulse(17'h10000, 17'h01D25, 8'd1, 24'hABCDEF, 0, 1'b0);
    // Three 0 bits, stray start at T+10, start held through done (accept at T+65).
    run_pulse(17'h00001, 17'h01D25, 8'd3, 24'h123456, 10, 1'b1);
    run_pulse(17'h0B00F, 17'h01D25, 8'd2, 24'h000777, 0, 1'b0);

    // bit_count=0 request while idle is ignored.
    bus.seed = 17'h1FFFF; bus.polynomial = 17'h01D25; bus.bit_count = 8'd0;
    bus.sys_ts = 24'h555555; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("zero_cnt_idle", {28'd0, bus.envelop_wire, bus.data_wire, bus.busy, bus.done}, 32'h8);
      tick();
    end
    chk("zero_cnt_final", {15'd0, bus.final_state}, {15'd0, last_final});
    chk("zero_cnt_ts", {8'd0, bus.tx_ts}, {8'd0, last_ts});

    // seed=0 gives all zeros and final_state 0.
    run_pulse(17'h00000, 17'h01D25, 8'd4, 24'h0000AA, 0, 1'b0);
    for (int i = 0; i < 3; i++)
      run_pulse(17'($urandom), 17'($urandom), 8'($urandom_range(1, 6)), 24'($urandom), 0, 1'b0);

    // Reset during SEND abandons the pulse.
    bus.seed = 17'h1ACE1; bus.polynomial = 17'h01D25; bus.bit_count = 8'd10;
    bus.sys_ts = 24'h00BEEF; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 2; c <= 20; c++) tick();
    chk("pre_rst_send", {31'd0, bus.envelop_wire}, 32'h0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_wave", {28'd0, bus.envelop_wire, bus.data_wire, bus.busy, bus.done}, 32'h8);
    chk("mid_rst_final", {15'd0, bus.final_state}, 32'h0);
    chk("mid_rst_ts", {8'd0, bus.tx_ts}, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    last_final = '0;
    run_pulse(17'h1ACE1, 17'h01D25, 8'd5, 24'h00C0DE, 0, 1'b0);

    chk("sb_drained", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
